ysyx_23060208_clint: RTL and testbench
======================================

Name: ysyx_23060208_clint

Overview:
- AXI4-Lite read-only slave holding the 64-bit machine timer (mtime), exposed to software as the RTC.
- Sits directly downstream of the memory arbiter: it receives the arbiter's clint_araddr_o, clint_arvalid_o and clint_rready_o, and drives clint_arready_i, clint_rdata_i, clint_rresp_i and clint_rvalid_i.
- Returns the low word at BASE_ADDR and the high word at BASE_ADDR+4.
- A low-word read snapshots the high word, so software gets a tear-free 64-bit read as a low/high pair.

Parameters:
- DATA_WIDTH, 32, read data width.
- ADDR_WIDTH, 32, read address width.
- BASE_ADDR, 32'ha000_0048, address of the mtime low word. The high word is at BASE_ADDR+4.
- TICK_DIV, 1, number of clk cycles per mtime increment. Must be ≥1.
- MTIME_RST, 64'h0, value loaded into mtime on reset. Allows testing near the wrap points.

Ports:
- clk, input, 1, system clock; all logic is on the rising edge.
- rst, input, 1, synchronous active-high reset.
- araddr, input, ADDR_WIDTH, read address.
- arvalid, input, 1, read address valid.
- arready, output, 1, slave can accept a read address.
- rdata, output, DATA_WIDTH, read data.
- rresp, output, 2, read response: 2'b00 OKAY, 2'b10 SLVERR.
- rvalid, output, 1, read data valid.
- rready, input, 1, master accepts the read data.

Behaviour:
- Reset: one clock; rst is synchronous and active-high. While rst is sampled high:
  - state goes to IDLE.
  - arready=0, rvalid=0, rdata=0, rresp=0.
  - mtime=MTIME_RST, prescaler=0, snap_hi=0, snap_valid=0.
- A reset arriving mid-transaction abandons the transaction; no response is issued afterwards.
- mtime counter:
  - A prescaler counts 0..TICK_DIV-1. mtime increments by 1 in the cycle the prescaler equals TICK_DIV-1, and the prescaler returns to 0.
  - With TICK_DIV=1, mtime increments every cycle after reset.
  - mtime wraps from 64'hFFFF_FFFF_FFFF_FFFF to 0 silently.
  - Counting never stalls for bus activity.
- State machine, two states:
  - IDLE: arready=1 (registered; goes to 1 the first cycle after rst deasserts), rvalid=0. If arvalid && arready, the address is decoded, rdata and rresp are registered, and the state moves to RESP.
  - RESP: arready=0, rvalid=1. rdata and rresp are held stable until rready. When rvalid && rready, the state goes to IDLE: rvalid drops and arready rises on the next cycle.
- Latency: an AR handshake in cycle N gives rvalid=1 in cycle N+1. The minimum back-to-back spacing is 2 cycles per read. rready held high during the request counts as acceptance in cycle N+1.
- Decode (exact match on araddr):
  - araddr==BASE_ADDR: rdata = mtime[31:0] as sampled in the handshake cycle (pre-increment value); rresp=OKAY. Also snap_hi <= mtime[63:32] of the same sample, snap_valid <= 1.
  - araddr==BASE_ADDR+4: rresp=OKAY. If snap_valid, rdata=snap_hi and snap_valid <= 0. Otherwise rdata = live mtime[63:32].
  - Any other address: rdata=32'h0, rresp=SLVERR; snapshot state is unchanged.
- Low/high pairing:
  - Two consecutive low reads each refresh the snapshot.
  - A high read consumes the snapshot exactly once.
  - A carry from bit 31 into bit 32 between the low and high reads must not appear in the pair.
- arvalid while in RESP: ignored (arready=0). The master holds it until IDLE.
- araddr is sampled only in the handshake cycle; later changes have no effect.

Test Plan:
- Reset: MTIME_RST=0, TICK_DIV=1. Hold rst 3 cycles, then release; issue a low read once arready=1 → arready=0/rvalid=0 during reset; rvalid exactly 1 cycle after the handshake; rdata = cycles elapsed since reset release (±0 by cycle count); rresp=00.
- Carry tear: MTIME_RST=64'h0000_0000_FFFF_FFF0. Read low at cycle 10 after reset, wait 20 cycles, then read high → low = 32'hFFFF_FFFA; high = 32'h0 (snapshot), not 1. A second high read returns 32'h1 (live).
- Backpressure: hold rready=0 for 5 cycles after rvalid → rvalid, rdata and rresp stay stable; arready=0 throughout. arvalid with a new address during the wait is not accepted. After rready=1, arready=1 on the next cycle.
- Bad address: araddr=32'ha000_0050 → rresp=2'b10, rdata=0; snapshot unaffected (a subsequent high read after an earlier low read still returns snap_hi).
- Prescaler: TICK_DIV=4, MTIME_RST=0. Read low 17 cycles after reset release → rdata=4. mtime steps once every 4 cycles.
- Reset mid-transaction: assert rst in the RESP cycle while rready=0 → next cycle rvalid=0, arready=0, mtime=MTIME_RST. No stale response appears after release.

Source files
------------

// File: rtl/ysyx_23060208_clint.sv
// Read-only AXI4-Lite slave exposing the 64-bit machine timer (mtime).
// A low-word read latches the high word so a low/high pair is tear-free.
module ysyx_23060208_clint #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'ha000_0048,
    parameter int                    TICK_DIV   = 1,
    parameter logic [63:0]           MTIME_RST  = 64'h0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rvalid,
    input  logic                  rready
);

    localparam int                    PS_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PS_W-1:0]       PS_MAX  = PS_W'(TICK_DIV - 1);
    localparam logic [ADDR_WIDTH-1:0] HI_ADDR = BASE_ADDR + ADDR_WIDTH'(4);
    localparam logic [1:0]            RESP_OKAY   = 2'b00;
    localparam logic [1:0]            RESP_SLVERR = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t                state_reg, state_next;
    logic                  arready_reg;
    logic                  rvalid_reg;
    logic [DATA_WIDTH-1:0] rdata_reg, rdata_next;
    logic [1:0]            rresp_reg, rresp_next;
    logic [63:0]           mtime_reg;
    logic [PS_W-1:0]       prescaler_reg;
    logic [31:0]           snap_hi_reg, snap_hi_next;
    logic                  snap_valid_reg, snap_valid_next;
    logic                  ar_hs;
    logic                  tick;

    assign ar_hs = arready_reg && arvalid;
    assign tick  = (prescaler_reg == PS_MAX);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (ar_hs) state_next = RESP;
            RESP:    if (rvalid_reg && rready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Decode uses the pre-increment mtime of the handshake cycle.
    always_comb begin
        rdata_next      = rdata_reg;
        rresp_next      = rresp_reg;
        snap_hi_next    = snap_hi_reg;
        snap_valid_next = snap_valid_reg;
        if (araddr == BASE_ADDR) begin
            rdata_next      = DATA_WIDTH'(mtime_reg[31:0]);
            rresp_next      = RESP_OKAY;
            snap_hi_next    = mtime_reg[63:32];
            snap_valid_next = 1'b1;
        end else if (araddr == HI_ADDR) begin
            rresp_next      = RESP_OKAY;
            snap_valid_next = 1'b0;
            rdata_next      = snap_valid_reg ? DATA_WIDTH'(snap_hi_reg)
                                             : DATA_WIDTH'(mtime_reg[63:32]);
        end else begin
            rdata_next = '0;
            rresp_next = RESP_SLVERR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            arready_reg    <= 1'b0;
            rvalid_reg     <= 1'b0;
            rdata_reg      <= '0;
            rresp_reg      <= '0;
            snap_hi_reg    <= '0;
            snap_valid_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            arready_reg <= (state_next == IDLE);
            rvalid_reg  <= (state_next == RESP);
            if (ar_hs) begin
                rdata_reg      <= rdata_next;
                rresp_reg      <= rresp_next;
                snap_hi_reg    <= snap_hi_next;
                snap_valid_reg <= snap_valid_next;
            end
        end
    end

    // Free-running timer; bus traffic never stalls it.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtime_reg     <= MTIME_RST;
            prescaler_reg <= '0;
        end else if (tick) begin
            mtime_reg     <= mtime_reg + 64'd1;
            prescaler_reg <= '0;
        end else begin
            prescaler_reg <= prescaler_reg + PS_W'(1);
        end
    end

    assign arready = arready_reg;
    assign rvalid  = rvalid_reg;
    assign rdata   = rdata_reg;
    assign rresp   = rresp_reg;

endmodule

// File: tb/tb_ysyx_23060208_clint.sv
// Bench for ysyx_23060208_clint: three instances with different timer settings
// share one stimulus stream and are checked against a cycle-count timer model.
module tb_ysyx_23060208_clint;

    localparam logic [31:0] BASE = 32'ha000_0048;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        rready = 1'b0;

    logic        arready_o [3];
    logic        rvalid_o  [3];
    logic [31:0] rdata_o   [3];
    logic [1:0]  rresp_o   [3];

    int compared = 0;
    int mismatched = 0;

    logic [31:0] rd [3];
    logic [1:0]  rr [3];

    always #5 clk = ~clk;

    function automatic int td(int i);
        return (i == 2) ? 4 : 1;
    endfunction

    function automatic logic [63:0] rstv(int i);
        return (i == 1) ? 64'h0000_0000_FFFF_FFF0 : 64'h0;
    endfunction

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            ysyx_23060208_clint #(
                .DATA_WIDTH(32),
                .ADDR_WIDTH(32),
                .BASE_ADDR (BASE),
                .TICK_DIV  ((gi == 2) ? 4 : 1),
                .MTIME_RST ((gi == 1) ? 64'h0000_0000_FFFF_FFF0 : 64'h0)
            ) u_dut (
                .clk    (clk),
                .rst    (rst),
                .araddr (araddr),
                .arvalid(arvalid),
                .arready(arready_o[gi]),
                .rdata  (rdata_o[gi]),
                .rresp  (rresp_o[gi]),
                .rvalid (rvalid_o[gi]),
                .rready (rready)
            );
        end
    endgenerate

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Timer model: mtime = MTIME_RST + floor(cycles since release / TICK_DIV).
    initial begin
        bit          live = 0;
        longint      k = 0;
        bit          e_ar = 0;
        bit          e_rv = 0;
        logic [1:0]  e_resp = 0;
        logic [31:0] e_data [3];
        logic [31:0] snap [3];
        bit          sv [3];
        logic [63:0] mt;
        forever begin
            @(negedge clk);
            if (live) begin
                for (int i = 0; i < 3; i++) begin
                    check($sformatf("arready[%0d]", i), 64'(arready_o[i]), 64'(e_ar));
                    check($sformatf("rvalid[%0d]", i), 64'(rvalid_o[i]), 64'(e_rv));
                    if (e_rv) begin
                        check($sformatf("rdata[%0d]", i), 64'(rdata_o[i]), 64'(e_data[i]));
                        check($sformatf("rresp[%0d]", i), 64'(rresp_o[i]), 64'(e_resp));
                    end
                end
            end
            if (rst) begin
                live = 1; k = 0; e_ar = 0; e_rv = 0; e_resp = 0;
                for (int i = 0; i < 3; i++) begin
                    e_data[i] = 0; snap[i] = 0; sv[i] = 0;
                end
            end else if (live) begin
                if (e_ar && arvalid) begin
                    e_ar = 0; e_rv = 1;
                    for (int i = 0; i < 3; i++) begin
                        mt = rstv(i) + 64'(k / longint'(td(i)));
                        if (araddr == BASE) begin
                            e_data[i] = mt[31:0]; snap[i] = mt[63:32]; sv[i] = 1; e_resp = 2'b00;
                        end else if (araddr == BASE + 32'd4) begin
                            e_data[i] = sv[i] ? snap[i] : mt[63:32]; sv[i] = 0; e_resp = 2'b00;
                        end else begin
                            e_data[i] = 0; e_resp = 2'b10;
                        end
                    end
                end else if (e_rv) begin
                    if (rready) begin
                        e_rv = 0; e_ar = 1;
                    end
                end else begin
                    e_ar = 1;
                end
                k++;
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1; arvalid = 0; rready = 0;
        step(n);
        check("reset_arready", 64'(arready_o[0]), 64'd0);
        check("reset_rvalid", 64'(rvalid_o[0]), 64'd0);
        rst = 0;
    endtask

    task automatic read(input logic [31:0] addr);
        int n;
        check("idle_arready", 64'(arready_o[0]), 64'd1);
        araddr = addr; arvalid = 1;
        step(1);
        arvalid = 0; araddr = $urandom;
        check("latency_rvalid", 64'(rvalid_o[0]), 64'd1);
        n = 0;
        while (!rvalid_o[0] && n < 8) begin
            step(1);
            n++;
        end
        for (int i = 0; i < 3; i++) begin
            rd[i] = rdata_o[i];
            rr[i] = rresp_o[i];
        end
        rready = 1;
        step(1);
        rready = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected end before 1000000");
        $fatal(1);
    end

    initial begin
        logic [31:0] held;
        // Reset and prescaler: low read 17 cycles after release.
        do_reset(3);
        step(17);
        read(BASE);
        check("lo_k17_div1", 64'(rd[0]), 64'd17);
        check("lo_k17_div4", 64'(rd[2]), 64'd4);
        check("lo_k17_rst_f0", 64'(rd[1]), 64'h0000_0001);
        check("lo_k17_resp", 64'(rr[0]), 64'd0);

        // Carry tear across bit 31/32.
        do_reset(2);
        step(10);
        read(BASE);
        check("tear_lo", 64'(rd[1]), 64'hFFFF_FFFA);
        check("tear_lo_div1", 64'(rd[0]), 64'd10);
        check("tear_lo_div4", 64'(rd[2]), 64'd2);
        step(20);
        read(BASE + 32'd4);
        check("tear_hi_snap", 64'(rd[1]), 64'h0);
        read(BASE + 32'd4);
        check("tear_hi_live", 64'(rd[1]), 64'h1);

        // Bad address leaves the snapshot intact.
        read(BASE);
        read(32'ha000_0050);
        check("bad_resp", 64'(rr[0]), 64'h2);
        check("bad_data", 64'(rd[1]), 64'h0);
        read(BASE + 32'd4);
        check("bad_then_hi", 64'(rd[1]), 64'h1);

        // Backpressure with a competing request.
        araddr = BASE; arvalid = 1;
        step(1);
        araddr = BASE + 32'd4;
        held = rdata_o[1];
        repeat (5) begin
            step(1);
            check("bp_rvalid", 64'(rvalid_o[1]), 64'd1);
            check("bp_arready", 64'(arready_o[1]), 64'd0);
            check("bp_rdata", 64'(rdata_o[1]), 64'(held));
        end
        arvalid = 0; rready = 1;
        step(1);
        rready = 0;
        check("bp_release_arready", 64'(arready_o[1]), 64'd1);

        // Reset while a response is pending.
        araddr = BASE; arvalid = 1;
        step(1);
        arvalid = 0;
        rst = 1;
        step(1);
        check("midrst_rvalid", 64'(rvalid_o[0]), 64'd0);
        check("midrst_arready", 64'(arready_o[0]), 64'd0);
        rst = 0;
        repeat (3) begin
            step(1);
            check("midrst_no_stale", 64'(rvalid_o[0]), 64'd0);
        end
        read(BASE);
        check("midrst_lo_div1", 64'(rd[0]), 64'd3);
        check("midrst_lo_rst_f0", 64'(rd[1]), 64'hFFFF_FFF3);
        check("midrst_lo_div4", 64'(rd[2]), 64'd0);

        // Randomized traffic, occasional resets.
        repeat (3000) begin
            step(1);
            rst     = ($urandom_range(0, 299) == 0);
            arvalid = ($urandom_range(0, 2) != 0);
            rready  = $urandom_range(0, 1) != 0;
            case ($urandom_range(0, 3))
                0: araddr = BASE;
                1: araddr = BASE + 32'd4;
                2: araddr = BASE + 32'd8;
                default: araddr = $urandom;
            endcase
        end
        rst = 0; arvalid = 0; rready = 1;
        step(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
